// File: rtl/uart_cmd_pkg.sv
// Shared state encoding and command/response byte codes for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StBusWr,
    StBusRd,
    StSend
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: cleared on demand, counts while enabled, flags the final cycle.
module uart_cmd_timeout #(
  parameter int unsigned Cycles = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;

  logic [CntW-1:0] cnt_q;

  assign expired = count && (cnt_q == CntW'(Cycles - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes 'W'/'R' frames from the RX FIFO into single bus transactions.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AddrBytes = ADDR_W / 8;
  localparam int unsigned DataBytes = DATA_W / 8;
  localparam int unsigned MaxBytes  = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) / 8;
  localparam int unsigned CntW      = $clog2(MaxBytes) + 1;

  // Single-byte replies sit in the MSB lane so SEND can shift uniformly.
  localparam logic [DATA_W-1:0] TxOk  = DATA_W'(RSP_OK) << (DATA_W - 8);
  localparam logic [DATA_W-1:0] TxErr = DATA_W'(RSP_ERR) << (DATA_W - 8);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   len_q;
  logic              is_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] tx_q;
  logic              bus_we_q;
  logic              bus_re_q;
  logic              err_q;
  logic              timed_out;

  assign rd_uart   = (state_q inside {StIdle, StGetAddr, StGetData}) && !rx_empty;
  assign wr_uart   = (state_q == StSend) && !tx_full;
  assign w_data    = tx_q[DATA_W-1 -: 8];
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign busy      = (state_q != StIdle);
  assign err       = err_q;

`ifdef UART_CMD_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_count;

  assign tmr_clear = rd_uart || (state_q == StIdle);
  assign tmr_count = (state_q == StGetAddr) || (state_q == StGetData);

  uart_cmd_timeout #(
    .Cycles(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .count  (tmr_count),
    .expired(timed_out)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timed_out          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      len_q    <= '0;
      is_rd_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      bus_we_q <= 1'b0;
      bus_re_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_empty) begin
            cnt_q   <= '0;
            is_rd_q <= (r_data == CMD_RD);
            if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
              state_q <= StGetAddr;
            end else begin
              tx_q    <= TxErr;
              len_q   <= CntW'(1);
              err_q   <= 1'b1;
              state_q <= StSend;
            end
          end
        end
        StGetAddr: begin
          if (!rx_empty) begin
            addr_q <= (addr_q << 8) | ADDR_W'(r_data);
            if (cnt_q == CntW'(AddrBytes - 1)) begin
              cnt_q <= '0;
              if (is_rd_q) begin
                bus_re_q <= 1'b1;
                state_q  <= StBusRd;
              end else begin
                state_q <= StGetData;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else if (timed_out) begin
            tx_q    <= TxErr;
            len_q   <= CntW'(1);
            err_q   <= 1'b1;
            state_q <= StSend;
          end
        end
        StGetData: begin
          if (!rx_empty) begin
            wdata_q <= (wdata_q << 8) | DATA_W'(r_data);
            if (cnt_q == CntW'(DataBytes - 1)) begin
              cnt_q    <= '0;
              bus_we_q <= 1'b1;
              state_q  <= StBusWr;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else if (timed_out) begin
            tx_q    <= TxErr;
            len_q   <= CntW'(1);
            err_q   <= 1'b1;
            state_q <= StSend;
          end
        end
        StBusWr: begin
          if (bus_ack) begin
            bus_we_q <= 1'b0;
            tx_q     <= TxOk;
            len_q    <= CntW'(1);
            state_q  <= StSend;
          end
        end
        StBusRd: begin
          if (bus_ack) begin
            bus_re_q <= 1'b0;
            tx_q     <= bus_rdata;
            len_q    <= CntW'(DataBytes);
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (!tx_full) begin
            tx_q  <= tx_q << 8;
            len_q <= len_q - CntW'(1);
            if (len_q == CntW'(1)) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: FIFO and bus slave models, frame-level reference model.
module tb_uart_cmd_ctrl;

  localparam int unsigned AddrW      = 8;
  localparam int unsigned DataW      = 16;
  localparam int unsigned TimeoutCyc = 100;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_empty = 1'b1;
  logic [7:0]  r_data = 8'h00;
  logic        tx_full = 1'b0;
  logic [15:0] bus_rdata = 16'h0000;
  logic        bus_ack = 1'b0;
  logic        rd_uart, wr_uart, bus_we, bus_re, busy, err;
  logic [7:0]  w_data;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];
  logic [15:0] slave_mem[256];
  logic [15:0] ref_mem[256];

  int exp_err = 0, err_seen = 0, pushes = 0;
  int bus_delay = -1, ack_wait = -1;
  bit rand_stall = 1'b0, force_full = 1'b0;
  bit req_prev = 1'b0, err_prev = 1'b0;
  logic [7:0] mon_byte;
  bus_t       mon_exp, mon_got;

  uart_cmd_ctrl #(
    .ADDR_W     (AddrW),
    .DATA_W     (DataW),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_empty (rx_empty),
    .r_data   (r_data),
    .rd_uart  (rd_uart),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic fail_line(input string name, input logic [31:0] act, input logic [31:0] exp);
    fails++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) fail_line(name, act, exp);
  endtask

  // Reference model: what one whole frame must produce on the bus and on the TX side.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [15:0] data);
    bus_t t;
    rx_q.push_back(cmd);
    if (cmd == 8'h57) begin
      rx_q.push_back(addr);
      rx_q.push_back(data[15:8]);
      rx_q.push_back(data[7:0]);
      t.we = 1'b1; t.addr = addr; t.wdata = data;
      exp_bus.push_back(t);
      ref_mem[addr] = data;
      exp_tx.push_back(8'h4B);
    end else if (cmd == 8'h52) begin
      rx_q.push_back(addr);
      t.we = 1'b0; t.addr = addr; t.wdata = 16'h0000;
      exp_bus.push_back(t);
      exp_tx.push_back(ref_mem[addr][15:8]);
      exp_tx.push_back(ref_mem[addr][7:0]);
    end else begin
      exp_tx.push_back(8'h45);
      exp_err++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!(rx_q.size() == 0 && exp_tx.size() == 0 && exp_bus.size() == 0 && !busy)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_busy", busy, 1'b0);
    check_eq("drain_pending", exp_tx.size() + exp_bus.size() + rx_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_bus_we", bus_we, 1'b0);
    check_eq("rst_bus_re", bus_re, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
  endtask

  // Input driver: FIFO heads, stalls and bus slave, updated just after each rising edge.
  always @(posedge clk) begin
    #2;
    rx_empty = (rx_q.size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
    r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    tx_full  = force_full || (rand_stall && $urandom_range(0, 3) == 0);
    bus_ack  = 1'b0;
    if (bus_we || bus_re) begin
      if (ack_wait < 0) ack_wait = (bus_delay >= 0) ? bus_delay : int'($urandom_range(0, 5));
      if (ack_wait == 0) begin
        bus_ack   = 1'b1;
        bus_rdata = slave_mem[bus_addr];
        ack_wait  = -1;
      end else begin
        ack_wait--;
      end
    end else begin
      ack_wait  = -1;
      bus_ack   = rand_stall && ($urandom_range(0, 9) == 0);
      bus_rdata = 16'($urandom);
    end
  end

  // Monitor: FIFO pops/pushes, bus requests and err pulses checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_uart) begin
        check_eq("rd_while_empty", rx_empty, 1'b0);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      if (wr_uart) begin
        pushes++;
        check_eq("wr_while_full", tx_full, 1'b0);
        if (exp_tx.size() == 0) begin
          fail_line("tx_unexpected", w_data, 0);
        end else begin
          mon_byte = exp_tx.pop_front();
          check_eq("tx_byte", w_data, mon_byte);
        end
      end
      if (bus_we || bus_re) check_eq("we_re_exclusive", bus_we & bus_re, 1'b0);
      if ((bus_we || bus_re) && !req_prev) begin
        mon_got.we    = bus_we;
        mon_got.addr  = bus_addr;
        mon_got.wdata = bus_we ? bus_wdata : 16'h0000;
        if (exp_bus.size() == 0) begin
          fail_line("bus_unexpected", 32'(mon_got), 0);
        end else begin
          mon_exp = exp_bus.pop_front();
          check_eq("bus_txn", 32'(mon_got), 32'(mon_exp));
        end
      end
      if (bus_we && bus_ack) slave_mem[bus_addr] = bus_wdata;
      if (err) begin
        err_seen++;
        check_eq("err_pulse_width", err_prev, 1'b0);
      end
      req_prev = bus_we || bus_re;
      err_prev = err;
    end else begin
      req_prev = 1'b0;
      err_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got 0x0, expected 0x1 (simulation time limit)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, mm, r;
    logic [7:0] cmd;
    bus_t t;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 16'($urandom);
      ref_mem[i]   = slave_mem[i];
    end

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rd_uart", rd_uart, 1'b0);
    check_eq("reset_wr_uart", wr_uart, 1'b0);
    check_eq("reset_w_data", w_data, 8'h00);
    check_eq("reset_bus_addr", bus_addr, 8'h00);
    check_eq("reset_bus_wdata", bus_wdata, 16'h0000);
    check_eq("reset_bus_we", bus_we, 1'b0);
    check_eq("reset_bus_re", bus_re, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_err", err, 1'b0);
    reset_n = 1'b1;

    // Directed write, then read of a preloaded word.
    bus_delay = 2;
    send_frame(8'h57, 8'h10, 16'hABCD);
    wait_idle(200);
    check_eq("write_mem", slave_mem[8'h10], 16'hABCD);

    slave_mem[8'h22] = 16'h1234;
    ref_mem[8'h22]   = 16'h1234;
    bus_delay = 3;
    send_frame(8'h52, 8'h22, 16'h0000);
    wait_idle(200);

    // Bad command followed by a good read.
    slave_mem[8'h05] = 16'h00FF;
    ref_mem[8'h05]   = 16'h00FF;
    send_frame(8'h41, 8'h00, 16'h0000);
    send_frame(8'h52, 8'h05, 16'h0000);
    wait_idle(200);
    check_eq("err_after_bad", err_seen, exp_err);

    // TX FIFO held full across the read reply.
    bus_delay  = 1;
    force_full = 1'b1;
    send_frame(8'h52, 8'h10, 16'h0000);
    p0 = pushes;
    repeat (30) @(negedge clk);
    check_eq("stall_no_push", pushes - p0, 0);
    check_eq("stall_busy", busy, 1'b1);
    force_full = 1'b0;
    wait_idle(200);
    check_eq("stall_pushes", pushes - p0, 2);

    // Partial frame then silence.
    p0 = pushes;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h10);
`ifdef UART_CMD_TIMEOUT_EN
    exp_tx.push_back(8'h45);
    exp_err++;
    repeat (TimeoutCyc + 40) @(negedge clk);
    check_eq("timeout_idle", busy, 1'b0);
    check_eq("timeout_tx", pushes - p0, 1);
    check_eq("timeout_err", err_seen, exp_err);
`else
    repeat (TimeoutCyc + 40) @(negedge clk);
    check_eq("no_timeout_busy", busy, 1'b1);
    check_eq("no_timeout_tx", pushes - p0, 0);
    pulse_reset();
`endif

    // Reset while a write waits for its ack.
    bus_delay = 100000;
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h10);
    rx_q.push_back(8'hAB);
    rx_q.push_back(8'hCD);
    t.we = 1'b1; t.addr = 8'h10; t.wdata = 16'hABCD;
    exp_bus.push_back(t);
    r = 0;
    while (!bus_we && r < 100) begin
      @(negedge clk);
      r++;
    end
    check_eq("reach_bus_wr", bus_we, 1'b1);
    pulse_reset();
    exp_bus.delete();
    bus_delay = 3;
    send_frame(8'h52, 8'h22, 16'h0000);
    wait_idle(200);

    // Randomized frames with RX/TX/bus stalls and stray acks.
    rand_stall = 1'b1;
    bus_delay  = -1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) cmd = 8'h57;
      else if (r < 9) cmd = 8'h52;
      else begin
        cmd = 8'($urandom);
        while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
      end
      send_frame(cmd, 8'($urandom_range(0, 15)), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(20000);
    rand_stall = 1'b0;

    mm = 0;
    for (int i = 0; i < 256; i++) if (slave_mem[i] !== ref_mem[i]) mm++;
    check_eq("mem_image", mm, 0);
    check_eq("err_count", err_seen, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
